// File: rtl/sdc_dq_ctrl_if.sv
// Command/data/pad bundle between the command sequencer, the DQ controller and the DQ IO wrapper.
interface sdc_dq_ctrl_if #(
  parameter int unsigned DW = 32
);
  logic          wr_start;
  logic          rd_start;
  logic [DW-1:0] wr_data;
  logic          wr_data_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ready;
  logic          cmd_err;
  logic [DW-1:0] sdc_dq_o;
  logic [DW-1:0] sdc_dq_t;
  logic [DW-1:0] sdc_dq_i;

  modport slave (
    input  wr_start, rd_start, wr_data, sdc_dq_i,
    output wr_data_req, rd_data, rd_valid, ready, cmd_err, sdc_dq_o, sdc_dq_t
  );

  modport master (
    output wr_start, rd_start, wr_data, sdc_dq_i,
    input  wr_data_req, rd_data, rd_valid, ready, cmd_err, sdc_dq_o, sdc_dq_t
  );
endinterface

// File: rtl/sdc_dq_ctrl.sv
// DQ pad direction and burst sequencer: write preamble/postamble, read capture
// after CL cycles, and a bus turnaround gap after every burst.
module sdc_dq_ctrl #(
  parameter int unsigned DW   = 32,
  parameter int unsigned BL   = 4,
  parameter int unsigned CL   = 2,
  parameter int unsigned TURN = 2
) (
  input  logic         sdc_clk,
  input  logic         sdc_rst_n,
  sdc_dq_ctrl_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] BL_LAST   = CW'(BL - 1);
  localparam logic [CW-1:0] CL_LAST   = CW'(CL - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PRE,
    ST_WR_DATA,
    ST_WR_POST,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_TURN
  } state_t;

  // With no turnaround gap a burst returns straight to idle.
  localparam state_t ST_AFTER = (TURN == 0) ? ST_IDLE : ST_TURN;

  state_t        state;
  logic [CW-1:0] cnt;

  assign bus.ready       = (state == ST_IDLE);
  assign bus.wr_data_req = (state == ST_WR_PRE) ||
                           ((state == ST_WR_DATA) && (cnt < BL_LAST));

  always_ff @(posedge sdc_clk or negedge sdc_rst_n) begin
    if (!sdc_rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bus.sdc_dq_t <= {DW{1'b1}};
      bus.sdc_dq_o <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.cmd_err  <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      // Both requests in idle drop the write; any request while busy is dropped.
      bus.cmd_err  <= (state != ST_IDLE) ? (bus.wr_start | bus.rd_start)
                                         : (bus.wr_start & bus.rd_start);
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (bus.rd_start) begin
            state <= ST_RD_WAIT;
          end else if (bus.wr_start) begin
            state        <= ST_WR_PRE;
            bus.sdc_dq_t <= '0;
            bus.sdc_dq_o <= '0;
          end
        end
        ST_WR_PRE: begin
          state        <= ST_WR_DATA;
          cnt          <= '0;
          bus.sdc_dq_o <= bus.wr_data;
        end
        ST_WR_DATA: begin
          if (cnt == BL_LAST) begin
            state        <= ST_WR_POST;
            cnt          <= '0;
            bus.sdc_dq_o <= '0;
          end else begin
            cnt          <= cnt + CW'(1);
            bus.sdc_dq_o <= bus.wr_data;
          end
        end
        ST_WR_POST: begin
          state        <= ST_AFTER;
          cnt          <= '0;
          bus.sdc_dq_t <= {DW{1'b1}};
          bus.sdc_dq_o <= '0;
        end
        ST_RD_WAIT: begin
          if (cnt == CL_LAST) begin
            state <= ST_RD_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RD_DATA: begin
          bus.rd_data  <= bus.sdc_dq_i;
          bus.rd_valid <= 1'b1;
          if (cnt == BL_LAST) begin
            state <= ST_AFTER;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_TURN: begin
          if (cnt == TURN_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_dq_ctrl.sv
// Bench for sdc_dq_ctrl: a cycle-timeline reference model fills expectation
// tables and data queues at issue time; a negedge monitor compares every cycle.
module tb_sdc_dq_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned BL   = 4;
  localparam int unsigned CL   = 2;
  localparam int unsigned TURN = 2;
  localparam int N = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  sdc_dq_ctrl_if #(.DW(DW)) bus ();

  sdc_dq_ctrl #(.DW(DW), .BL(BL), .CL(CL), .TURN(TURN)) dut (
    .sdc_clk   (clk),
    .sdc_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle behaviour, indexed by cycle number.
  bit exp_busy [N];
  bit exp_drv  [N];
  bit exp_req  [N];
  bit exp_rv   [N];
  bit exp_err  [N];
  logic [DW-1:0] pad [N];

  logic [DW-1:0] wd_q [$];   // words the bench hands out on wr_data_req
  logic [DW-1:0] wq   [$];   // expected pad words while the bus is driven
  logic [DW-1:0] rq   [$];   // expected read words
  int  free_at = 0;
  bit  dir_wr  = 1'b0;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void mark(ref bit arr [N], input int from, input int to);
    for (int t = from; t <= to; t++) if (t >= 0 && t < N) arr[t] = 1'b1;
  endfunction

  // Reference model: command behaviour derived from the documented timelines.
  function automatic void model_cmd(int c, bit w, bit r);
    logic [DW-1:0] word;
    if (!(w || r)) return;
    if (c < free_at) begin
      if (c + 1 < N) exp_err[c+1] = 1'b1;
      return;
    end
    if (r) begin
      if (w && c + 1 < N) exp_err[c+1] = 1'b1;
      for (int k = 0; k < int'(BL); k++) rq.push_back(pad[c + int'(CL) + 1 + k]);
      mark(exp_rv, c + int'(CL) + 2, c + int'(CL) + int'(BL) + 1);
      mark(exp_busy, c + 1, c + int'(CL) + int'(BL) + int'(TURN));
      free_at = c + int'(CL) + int'(BL) + 1 + int'(TURN);
    end else begin
      wq.push_back('0);
      for (int k = 0; k < int'(BL); k++) begin
        word = dir_wr ? 32'(32'h1111_1111 * (k + 1)) : $urandom;
        wd_q.push_back(word);
        wq.push_back(word);
      end
      wq.push_back('0);
      mark(exp_drv, c + 1, c + int'(BL) + 2);
      mark(exp_req, c + 1, c + int'(BL));
      mark(exp_busy, c + 1, c + int'(BL) + 2 + int'(TURN));
      free_at = c + int'(BL) + 3 + int'(TURN);
    end
  endfunction

  function automatic void model_reset(int c);
    for (int t = c; t < N; t++) begin
      exp_busy[t] = 1'b0; exp_drv[t] = 1'b0; exp_req[t] = 1'b0;
      exp_rv[t]   = 1'b0; exp_err[t] = 1'b0;
    end
    wd_q.delete(); wq.delete(); rq.delete();
    free_at = c;
  endfunction

  // Pad input and write-data drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    bus.sdc_dq_i = pad[cyc % N];
    if (bus.wr_data_req && wd_q.size() > 0) bus.wr_data = wd_q.pop_front();
    else bus.wr_data = $urandom;
  end

  // Monitor: compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (cyc < N) begin
      chk("ready", 32'(bus.ready), 32'(!exp_busy[cyc]));
      chk("dq_t", bus.sdc_dq_t, exp_drv[cyc] ? 32'h0 : 32'hFFFF_FFFF);
      if (bus.sdc_dq_t == '0) begin
        if (wq.size() == 0) chk("dq_o_unexpected", 32'(1), 32'(0));
        else begin
          e = wq.pop_front();
          chk("dq_o", bus.sdc_dq_o, e);
        end
      end else begin
        chk("dq_o_idle", bus.sdc_dq_o, 32'h0);
      end
      chk("wr_data_req", 32'(bus.wr_data_req), 32'(exp_req[cyc]));
      chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rv[cyc]));
      if (bus.rd_valid) begin
        if (rq.size() == 0) chk("rd_data_unexpected", 32'(1), 32'(0));
        else begin
          e = rq.pop_front();
          chk("rd_data", bus.rd_data, e);
        end
      end
      chk("cmd_err", 32'(bus.cmd_err), 32'(exp_err[cyc]));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit w, bit r);
    bus.wr_start = w;
    bus.rd_start = r;
    model_cmd(cyc, w, r);
    next_cycle();
    bus.wr_start = 1'b0;
    bus.rd_start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && cyc < free_at; i++) next_cycle();
  endtask

  initial begin
    int c0;
    int sel;
    for (int t = 0; t < N; t++) pad[t] = $urandom;
    bus.wr_start = 1'b0;
    bus.rd_start = 1'b0;
    bus.wr_data  = '0;
    bus.sdc_dq_i = pad[0];

    // Reset, then ten idle cycles.
    repeat (3) next_cycle();
    #2 rst_n = 1'b1;
    chk("rd_data_reset", bus.rd_data, 32'h0);
    repeat (10) next_cycle();

    // Directed write burst with fixed words.
    dir_wr = 1'b1;
    issue(1'b1, 1'b0);
    dir_wr = 1'b0;
    wait_ready();
    next_cycle();

    // Directed read burst with A000_000k on the pad in the sample window.
    for (int k = 0; k < int'(BL); k++) pad[cyc + int'(CL) + 1 + k] = 32'hA000_0000 + 32'(k);
    issue(1'b0, 1'b1);
    wait_ready();

    // Simultaneous requests: read wins, write dropped.
    issue(1'b1, 1'b1);
    wait_ready();

    // Write request in cycle 3 of a read is ignored.
    issue(1'b0, 1'b1);
    next_cycle();
    next_cycle();
    issue(1'b1, 1'b0);
    wait_ready();

    // Back-to-back: read issued at the first ready cycle after a write.
    issue(1'b1, 1'b0);
    wait_ready();
    issue(1'b0, 1'b1);
    wait_ready();
    next_cycle();

    // Reset mid-write: bus released without any clock edge.
    c0 = cyc;
    issue(1'b1, 1'b0);
    while (cyc < c0 + 3) next_cycle();
    #2 rst_n = 1'b0;
    model_reset(cyc);
    #1;
    chk("rst_dq_t", bus.sdc_dq_t, 32'hFFFF_FFFF);
    chk("rst_dq_o", bus.sdc_dq_o, 32'h0);
    chk("rst_wr_data_req", 32'(bus.wr_data_req), 32'(0));
    chk("rst_ready", 32'(bus.ready), 32'(1));
    next_cycle();
    next_cycle();
    #2 rst_n = 1'b1;
    free_at = cyc;
    repeat (3) next_cycle();

    // Randomized command traffic.
    repeat (400) begin
      sel = int'($urandom_range(0, 9));
      issue(sel == 0 || sel == 2, sel == 1 || sel == 2);
    end
    repeat (30) next_cycle();

    chk("wq_drained", 32'(wq.size()), 32'(0));
    chk("rq_drained", 32'(rq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
